// File: rtl/mem_io_responder_pkg.sv
// Shared definitions for the memory/IO responder: FSM state type,
// default I/O-mapped address and the seven-segment glyph table.
package mem_io_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2,
    HOLD = 2'd3
  } state_e;

  localparam logic [19:0] IO_ADDR_DEFAULT = 20'h0FFFF;

  // Active-low segments, bit order {g,f,e,d,c,b,a}; glyphs 0-9, A, b, C, d, E, F.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/mem_io_responder_if.sv
// CPU-side SRAM-style bus: active-low strobes, 20-bit word address,
// split write/read data buses and the access-complete pulse.
interface mem_io_responder_if;

  logic        CE;
  logic        UB;
  logic        LB;
  logic        OE;
  logic        WE;
  logic [19:0] A;
  logic [15:0] Data_CPU;
  logic [15:0] Data_Mem;
  logic        Ready;

  modport master (
    output CE, UB, LB, OE, WE, A, Data_CPU,
    input  Data_Mem, Ready
  );

  modport slave (
    input  CE, UB, LB, OE, WE, A, Data_CPU,
    output Data_Mem, Ready
  );

endinterface

// File: rtl/mem_io_responder_hex_driver.sv
// Nibble to active-low seven-segment decode.
module hex_driver
  import mem_io_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_LUT[nibble];

endmodule

// File: rtl/mem_io_responder.sv
// Memory-side responder: serves CPU reads/writes from an internal word RAM
// with byte-lane enables; IO_ADDR maps switches (read) and a display
// register (write) that drives four seven-segment digits.
// Optional build macro MEM_ACCESS_ERR_EN adds the Err output, pulsed with
// Ready for out-of-range accesses or accesses with both lanes disabled.
//
// state | meaning
// IDLE  | waiting for a request; writes are performed on acceptance
// BUSY  | read latency countdown
// DONE  | Ready high for this single cycle
// HOLD  | waiting for the request to drop before accepting another
module mem_io_responder
  import mem_io_pkg::*;
#(
  parameter int          DEPTH    = 256,
  parameter int          READ_LAT = 2,
  parameter logic [19:0] IO_ADDR  = IO_ADDR_DEFAULT
) (
  input  logic                Clk,
  input  logic                Reset,
  mem_io_responder_if.slave   bus,
  input  logic [15:0]         Switches,
  output logic [6:0]          HEX0,
  output logic [6:0]          HEX1,
  output logic [6:0]          HEX2,
  output logic [6:0]          HEX3
`ifdef MEM_ACCESS_ERR_EN
  ,
  output logic                Err
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT + 1) : 1;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_BUSY = BUSY;
  localparam logic [1:0] ST_DONE = DONE;
  localparam logic [1:0] ST_HOLD = HOLD;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [19:0]   a_q;
  logic          ub_q;
  logic          lb_q;
  logic [15:0]   data_mem;
  logic [15:0]   disp;
  logic          ready;
  logic [15:0]   ram [DEPTH];

  logic          req;
  logic          wr_req;
  logic [19:0]   a_sel;
  logic          ub_sel;
  logic          lb_sel;
  logic          sel_io;
  logic          sel_ram;
  logic [AW-1:0] ram_idx;
  logic [15:0]   lane_mask;
  logic [15:0]   rd_word;
  logic          done_now;
  logic          wr_now;

  assign req    = !bus.CE && (!bus.OE || !bus.WE);
  assign wr_req = !bus.WE;

  // In IDLE the live bus decides the target; afterwards the sampled copy does,
  // so address/lane changes after acceptance are ignored.
  always_comb begin
    a_sel  = a_q;
    ub_sel = ub_q;
    lb_sel = lb_q;
    if (state == ST_IDLE) begin
      a_sel  = bus.A;
      ub_sel = bus.UB;
      lb_sel = bus.LB;
    end
  end

  assign sel_io    = (a_sel == IO_ADDR);
  assign sel_ram   = !sel_io && ((a_sel >> AW) == 20'd0);
  assign ram_idx   = a_sel[AW-1:0];
  assign lane_mask = {{8{!ub_sel}}, {8{!lb_sel}}};

  // Read data selection with disabled lanes forced to zero.
  always_comb begin
    rd_word = 16'h0000;
    if (sel_io) begin
      rd_word = Switches & lane_mask;
    end else if (sel_ram) begin
      rd_word = ram[ram_idx] & lane_mask;
    end
  end

  assign done_now = ((state == ST_IDLE) && req && (wr_req || (READ_LAT == 1))) ||
                    ((state == ST_BUSY) && (cnt <= CW'(1)));
  assign wr_now   = !Reset && (state == ST_IDLE) && req && wr_req;

  // RAM byte-lane writes; contents are deliberately not reset.
  always_ff @(posedge Clk) begin
    if (wr_now && sel_ram) begin
      if (!lb_sel) ram[ram_idx][7:0]  <= bus.Data_CPU[7:0];
      if (!ub_sel) ram[ram_idx][15:8] <= bus.Data_CPU[15:8];
    end
  end

  // Access sequencing, read data register, display register and Ready pulse.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      a_q      <= '0;
      ub_q     <= 1'b1;
      lb_q     <= 1'b1;
      data_mem <= 16'h0000;
      disp     <= 16'h0000;
      ready    <= 1'b0;
    end else begin
      ready <= done_now;
      case (state)
        ST_IDLE: begin
          if (req) begin
            a_q  <= bus.A;
            ub_q <= bus.UB;
            lb_q <= bus.LB;
            if (wr_req) begin
              if (sel_io) begin
                if (!lb_sel) disp[7:0]  <= bus.Data_CPU[7:0];
                if (!ub_sel) disp[15:8] <= bus.Data_CPU[15:8];
              end
              state <= ST_DONE;
            end else if (READ_LAT == 1) begin
              data_mem <= rd_word;
              state    <= ST_DONE;
            end else begin
              cnt   <= CW'(READ_LAT - 1);
              state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (cnt <= CW'(1)) begin
            data_mem <= rd_word;
            state    <= ST_DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_DONE: state <= ST_HOLD;
        ST_HOLD: if (!req) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MEM_ACCESS_ERR_EN
  logic err_q;

  // Error flag raised alongside Ready for unmapped or lane-less accesses.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= done_now && ((!sel_io && !sel_ram) || (ub_sel && lb_sel));
    end
  end

  assign Err = err_q;
`endif

  assign bus.Data_Mem = data_mem;
  assign bus.Ready    = ready;

  hex_driver u_hex0 (.nibble(disp[3:0]),   .seg(HEX0));
  hex_driver u_hex1 (.nibble(disp[7:4]),   .seg(HEX1));
  hex_driver u_hex2 (.nibble(disp[11:8]),  .seg(HEX2));
  hex_driver u_hex3 (.nibble(disp[15:12]), .seg(HEX3));

endmodule

// File: tb/tb_mem_io_responder.sv
// Testbench for mem_io_responder: directed vector table, multi-cycle corner
// sequences (held request, reset mid-read, reset with write) and randomized
// accesses against a behavioural memory/display model.
module tb_mem_io_responder;

  localparam int READ_LAT = 2;
  localparam logic [19:0] IO = 20'h0FFFF;

  logic        Clk;
  logic        Reset;
  logic [15:0] Switches;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3;
`ifdef MEM_ACCESS_ERR_EN
  logic        Err;
`endif

  mem_io_responder_if bus ();

  mem_io_responder #(.DEPTH(256), .READ_LAT(READ_LAT), .IO_ADDR(20'h0FFFF)) dut (
    .Clk(Clk), .Reset(Reset), .bus(bus), .Switches(Switches),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3)
`ifdef MEM_ACCESS_ERR_EN
    , .Err(Err)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [15:0] m_ram [256];
  logic [15:0] m_disp;
  logic [15:0] m_last;
  logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct {
    bit          wr;
    bit          both;
    bit          ub;
    bit          lb;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic [15:0] sw;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic logic [15:0] lane_mask(input bit ub, input bit lb);
    return {(ub ? 8'h00 : 8'hFF), (lb ? 8'h00 : 8'hFF)};
  endfunction

  function automatic logic [15:0] model_read(input logic [19:0] addr, input bit ub, input bit lb);
    if (addr == IO) return Switches & lane_mask(ub, lb);
    if (addr < 20'd256) return m_ram[addr[7:0]] & lane_mask(ub, lb);
    return 16'h0000;
  endfunction

  function automatic bit model_err(input logic [19:0] addr, input bit ub, input bit lb);
    return ((addr != IO) && (addr >= 20'd256)) || (ub && lb);
  endfunction

  task automatic model_write(input logic [19:0] addr, input bit ub, input bit lb, input logic [15:0] d);
    logic [15:0] m;
    m = lane_mask(ub, lb);
    if (addr == IO) m_disp = (m_disp & ~m) | (d & m);
    else if (addr < 20'd256) m_ram[addr[7:0]] = (m_ram[addr[7:0]] & ~m) | (d & m);
  endtask

  task automatic check_hex(input string tag);
    check({tag, " HEX0"}, {25'd0, HEX0}, {25'd0, seg_tab[m_disp[3:0]]});
    check({tag, " HEX1"}, {25'd0, HEX1}, {25'd0, seg_tab[m_disp[7:4]]});
    check({tag, " HEX2"}, {25'd0, HEX2}, {25'd0, seg_tab[m_disp[11:8]]});
    check({tag, " HEX3"}, {25'd0, HEX3}, {25'd0, seg_tab[m_disp[15:12]]});
  endtask

  task automatic bus_idle();
    bus.CE = 1'b1; bus.OE = 1'b1; bus.WE = 1'b1;
    bus.UB = 1'b1; bus.LB = 1'b1;
  endtask

  // One complete access: drive, wait for Ready (bounded), check latency,
  // data, pulse width and the display, then release the bus.
  task automatic access(input bit wr, input bit both, input bit ub, input bit lb,
                        input logic [19:0] addr, input logic [15:0] wdata,
                        input logic [15:0] exp_rd, input string tag);
    int lat;
    bit seen;
    @(negedge Clk);
    bus.CE = 1'b0;
    bus.WE = wr ? 1'b0 : 1'b1;
    bus.OE = (wr && !both) ? 1'b1 : 1'b0;
    bus.UB = ub; bus.LB = lb; bus.A = addr; bus.Data_CPU = wdata;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 20) begin
      @(posedge Clk);
      lat++;
      @(negedge Clk);
      if (bus.Ready === 1'b1) seen = 1'b1;
    end
    check({tag, " ready_seen"}, {31'd0, seen}, 32'd1);
    check({tag, " latency"}, lat, wr ? 32'd1 : READ_LAT);
    check({tag, " data_mem"}, {16'd0, bus.Data_Mem}, {16'd0, (wr ? m_last : exp_rd)});
`ifdef MEM_ACCESS_ERR_EN
    check({tag, " err"}, {31'd0, Err}, {31'd0, model_err(addr, ub, lb)});
`endif
    if (wr) model_write(addr, ub, lb, wdata);
    else m_last = exp_rd;
    bus.A = ~addr;
    bus.Data_CPU = ~wdata;
    @(negedge Clk);
    check({tag, " ready_pulse_width"}, {31'd0, bus.Ready}, 32'd0);
    check_hex(tag);
    bus_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int pulses;
    logic [19:0] addrs [21];
    vecs.push_back('{1, 0, 0, 0, 20'h00010, 16'hBEEF, 16'h0000, 16'h0000});
    vecs.push_back('{0, 0, 0, 0, 20'h00010, 16'h0000, 16'h0000, 16'hBEEF});
    vecs.push_back('{1, 0, 1, 0, 20'h00010, 16'h1234, 16'h0000, 16'h0000});
    vecs.push_back('{0, 0, 0, 1, 20'h00010, 16'h0000, 16'h0000, 16'hBE00});
    vecs.push_back('{0, 0, 1, 0, 20'h00010, 16'h0000, 16'h0000, 16'h0034});
    vecs.push_back('{1, 0, 0, 0, 20'h0FFFF, 16'hC0DE, 16'h0000, 16'h0000});
    vecs.push_back('{0, 0, 0, 0, 20'h0FFFF, 16'h0000, 16'h5A5A, 16'h5A5A});
    vecs.push_back('{0, 0, 1, 0, 20'h0FFFF, 16'h0000, 16'h5A5A, 16'h005A});
    vecs.push_back('{0, 0, 0, 0, 20'h10003, 16'h0000, 16'h5A5A, 16'h0000});
    vecs.push_back('{1, 0, 0, 0, 20'h00100, 16'hFFFF, 16'h0000, 16'h0000});
    vecs.push_back('{0, 0, 0, 0, 20'h00100, 16'h0000, 16'h0000, 16'h0000});
    vecs.push_back('{1, 0, 1, 1, 20'h00010, 16'h0000, 16'h0000, 16'h0000});
    vecs.push_back('{0, 0, 0, 0, 20'h00010, 16'h0000, 16'h0000, 16'hBE34});
    vecs.push_back('{1, 1, 0, 0, 20'h000FF, 16'hA55A, 16'h0000, 16'h0000});
    vecs.push_back('{0, 0, 0, 0, 20'h000FF, 16'h0000, 16'h0000, 16'hA55A});

    bus_idle();
    bus.A = '0; bus.Data_CPU = '0;
    Switches = 16'h0000;
    m_disp = 16'h0000;
    m_last = 16'h0000;
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    check("reset ready", {31'd0, bus.Ready}, 32'd0);
    check("reset data_mem", {16'd0, bus.Data_Mem}, 32'd0);
    check_hex("reset");

    // Directed vector table
    foreach (vecs[i]) begin
      Switches = vecs[i].sw;
      access(vecs[i].wr, vecs[i].both, vecs[i].ub, vecs[i].lb, vecs[i].addr,
             vecs[i].wdata, vecs[i].exp, $sformatf("vec%0d", i));
      if (i == 5) begin
        check("C0DE HEX3 is C", {25'd0, HEX3}, 32'h46);
        check("C0DE HEX0 is E", {25'd0, HEX0}, 32'h06);
      end
    end

    // Request held for 10 cycles must be serviced exactly once
    @(negedge Clk);
    bus.CE = 1'b0; bus.WE = 1'b0; bus.OE = 1'b1; bus.UB = 1'b0; bus.LB = 1'b0;
    bus.A = 20'h00005; bus.Data_CPU = 16'h0001;
    pulses = 0;
    repeat (10) begin
      @(posedge Clk);
      @(negedge Clk);
      if (bus.Ready === 1'b1) pulses++;
    end
    check("held request ready pulses", pulses, 32'd1);
    model_write(20'h00005, 1'b0, 1'b0, 16'h0001);
    bus_idle();
    @(posedge Clk);
    @(negedge Clk);
    check("held release no ready", {31'd0, bus.Ready}, 32'd0);
    access(1'b0, 1'b0, 1'b0, 1'b0, 20'h00005, 16'h0000, 16'h0001, "held readback");
    access(1'b1, 1'b0, 1'b0, 1'b0, 20'h00005, 16'h0002, 16'h0000, "rerequest write");
    access(1'b0, 1'b0, 1'b0, 1'b0, 20'h00005, 16'h0000, 16'h0002, "rerequest read");

    // Reset while a read is in BUSY
    @(negedge Clk);
    bus.CE = 1'b0; bus.OE = 1'b0; bus.WE = 1'b1; bus.UB = 1'b0; bus.LB = 1'b0;
    bus.A = 20'h00010;
    @(posedge Clk);
    @(negedge Clk);
    check("busy no early ready", {31'd0, bus.Ready}, 32'd0);
    Reset = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    bus_idle();
    m_disp = 16'h0000;
    m_last = 16'h0000;
    check("abort ready", {31'd0, bus.Ready}, 32'd0);
    check("abort data_mem", {16'd0, bus.Data_Mem}, 32'd0);
    check_hex("abort");
    @(posedge Clk);
    @(negedge Clk);
    check("abort stays quiet", {31'd0, bus.Ready}, 32'd0);
    access(1'b0, 1'b0, 1'b0, 1'b0, 20'h00010, 16'h0000, 16'hBE34, "post abort read");

    // Write presented on the same edge as Reset must be dropped
    @(negedge Clk);
    Reset = 1'b1;
    bus.CE = 1'b0; bus.WE = 1'b0; bus.OE = 1'b1; bus.UB = 1'b0; bus.LB = 1'b0;
    bus.A = 20'h00010; bus.Data_CPU = 16'h0000;
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    bus_idle();
    m_last = 16'h0000;
    check("reset write ready", {31'd0, bus.Ready}, 32'd0);
    access(1'b0, 1'b0, 1'b0, 1'b0, 20'h00010, 16'h0000, 16'hBE34, "reset write dropped");

    // Randomized accesses against the model
    for (int k = 0; k < 16; k++) addrs[k] = 20'(k);
    addrs[16] = 20'h000FF; addrs[17] = IO; addrs[18] = 20'h00100;
    addrs[19] = 20'h10003; addrs[20] = 20'hFFFFF;
    for (int k = 0; k < 16; k++)
      access(1'b1, 1'b0, 1'b0, 1'b0, addrs[k], 16'($urandom), 16'h0000, $sformatf("init%0d", k));
    for (int n = 0; n < 60; n++) begin
      bit wr, both, ub, lb;
      logic [19:0] ad;
      logic [15:0] wd;
      wr = 1'($urandom); both = 1'($urandom); ub = 1'($urandom); lb = 1'($urandom);
      ad = addrs[$urandom_range(0, 20)];
      wd = 16'($urandom);
      Switches = 16'($urandom);
      access(wr, both, ub, lb, ad, wd, model_read(ad, ub, lb), $sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
